// File: rtl/uart_to_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_to_regfile_if
// Brief    : Received-byte stream in, register bank and status pulses out.
// Revision : 1.0
// ============================================================================
interface uart_to_regfile_if #(
  parameter int WORDSZ = 32,
  parameter int NREGS  = 4
);
  logic                      rx_valid;
  logic [7:0]                rx_data;
  logic                      rx_break;
  logic [NREGS*WORDSZ-1:0]   regs_flat;
  logic                      wr_strobe;
  logic [3:0]                wr_addr;
  logic                      frame_err;
  logic                      busy;

  modport master (
    output rx_valid, rx_data, rx_break,
    input  regs_flat, wr_strobe, wr_addr, frame_err, busy
  );

  modport slave (
    input  rx_valid, rx_data, rx_break,
    output regs_flat, wr_strobe, wr_addr, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_to_regfile.sv
`default_nettype none
// ============================================================================
// Module   : uart_to_regfile
// Brief    : Framed UART command parser writing multi-byte words to a bank.
// Revision : 1.0
// ============================================================================
module uart_to_regfile #(
  parameter int WORDSZ      = 32,
  parameter int NREGS       = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx_en,
  uart_to_regfile_if.slave   bus
);

  localparam int c_nbytes = WORDSZ / 8;
  localparam int c_bcw    = $clog2(c_nbytes + 1);
  localparam int c_tw     = $clog2(TIMEOUT_CYC);
  localparam logic [c_bcw-1:0] c_last    = c_bcw'(c_nbytes - 1);
  localparam logic [c_tw-1:0]  c_tmo_max = c_tw'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t                  r_state;
  logic [WORDSZ-1:0]       r_regs [NREGS];
  logic [WORDSZ-1:0]       r_shift;
  logic [c_bcw-1:0]        r_cnt;
  logic [c_tw-1:0]         r_tmo;
  logic [3:0]              r_addr;
  logic [3:0]              r_wr_addr;
  logic                    r_strobe;
  logic                    r_err;
  logic                    r_busy;

  logic [WORDSZ-1:0]       w_shift_next;
  logic [3:0]              w_op;
  logic [3:0]              w_a;
  logic                    w_a_ok;
  logic [NREGS*WORDSZ-1:0] w_flat;

  assign w_op   = bus.rx_data[7:4];
  assign w_a    = bus.rx_data[3:0];
  assign w_a_ok = ({1'b0, w_a} < 5'(NREGS));

  // A single-byte word has nothing to shift; the new byte is the whole word.
  generate
    if (WORDSZ > 8) begin : g_shift_wide
      assign w_shift_next = {r_shift[WORDSZ-9:0], bus.rx_data};
    end else begin : g_shift_byte
      assign w_shift_next = bus.rx_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_addr    <= '0;
      r_wr_addr <= '0;
      r_strobe  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      if (!rx_en) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_tmo   <= '0;
        r_busy  <= 1'b0;
      end else if (bus.rx_break) begin
        r_err   <= (r_state == S_DATA);
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_tmo   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.rx_valid) begin
              if (w_op == 4'hA && w_a_ok) begin
                r_addr  <= w_a;
                r_shift <= '0;
                r_cnt   <= '0;
                r_tmo   <= '0;
                r_state <= S_DATA;
                r_busy  <= 1'b1;
              end else if (w_op == 4'hC && w_a_ok) begin
                for (int k = 0; k < NREGS; k++)
                  if (w_a == 4'(k)) r_regs[k] <= '0;
                r_strobe  <= 1'b1;
                r_wr_addr <= w_a;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_DATA: begin
            // A byte arriving on the timeout cycle still counts.
            if (bus.rx_valid) begin
              r_shift <= w_shift_next;
              r_cnt   <= r_cnt + 1'b1;
              r_tmo   <= '0;
              if (r_cnt == c_last) begin
                for (int k = 0; k < NREGS; k++)
                  if (r_addr == 4'(k)) r_regs[k] <= w_shift_next;
                r_strobe  <= 1'b1;
                r_wr_addr <= r_addr;
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
              end
            end else if (r_tmo == c_tmo_max) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_tmo   <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_flat = '0;
    for (int k = 0; k < NREGS; k++) w_flat[k*WORDSZ +: WORDSZ] = r_regs[k];
  end

  assign bus.regs_flat = w_flat;
  assign bus.wr_strobe = r_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.frame_err = r_err;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_to_regfile.md
Name: uart_to_regfile

Overview:
Successor to the single-byte UART-to-register path. Consumes the received-byte stream from the existing uart_rx. Parses a framed command protocol and writes multi-byte words into a bank of NREGS registers of WORDSZ bits each. The bank is exported flat for LED drivers and other downstream logic, together with a write strobe and an error pulse.

Parameters:
WORDSZ, 32, register width in bits; must be a multiple of 8, range 8..64
NREGS, 4, number of registers; range 1..16
TIMEOUT_CYC, 1_000_000, maximum clk cycles allowed between bytes inside a frame; must be ≥2

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
rx_en  input  1  reception enable (slide switch); low forces FSM to IDLE, registers retained
rx_valid  input  1  one-cycle strobe from uart_rx, data valid
rx_data  input  8  received byte
rx_break  input  1  BREAK detected by uart_rx
regs_flat  output  NREGS*WORDSZ  register bank; reg k occupies bits [k*WORDSZ +: WORDSZ]
wr_strobe  output  1  one-cycle pulse after a register update
wr_addr  output  4  index of the last register written
frame_err  output  1  one-cycle pulse on a protocol error or abort
busy  output  1  high while a frame is in progress (state DATA)

Behaviour:
- Reset (resetn low, asynchronous): all registers 0, state IDLE, byte counter 0, timeout counter 0, wr_strobe 0, wr_addr 0, frame_err 0, busy 0.
- NBYTES = WORDSZ/8. Internal byte counter is clog2(NBYTES+1) bits. Timeout counter is clog2(TIMEOUT_CYC) bits.
- Header byte H: H[7:4] is the opcode, H[3:0] is the address A.
  - 0xA: write. NBYTES data bytes follow, MSB first.
  - 0xC: clear. Sets reg A to 0, no data bytes.
  - Any other opcode: error.
- IDLE, on rx_valid:
  - Opcode 0xA with A<NREGS: latch A, clear the shift register and counters, go to DATA.
  - Opcode 0xC with A<NREGS: reg A <= 0 on this edge. Next cycle wr_strobe=1 and wr_addr=A. Stay in IDLE.
  - Unknown opcode or A≥NREGS: frame_err pulses the next cycle. Stay in IDLE. No register change.
- DATA, per byte:
  - Each rx_valid shifts: shift <= {shift[WORDSZ-9:0], rx_data}, byte counter +1, timeout counter cleared.
  - On the rx_valid that delivers byte NBYTES: reg A <= {shift[WORDSZ-9:0], rx_data} on that edge. The next cycle has wr_strobe=1 and wr_addr=A. Go to IDLE.
- DATA, aborts:
  - With no rx_valid, the timeout counter increments. When it reaches TIMEOUT_CYC-1: go to IDLE, frame_err pulses, no write.
  - rx_valid wins over timeout in the same cycle.
  - rx_break high in any state: go to IDLE. frame_err pulses if the state was DATA. A concurrent rx_valid is ignored.
  - rx_en low: synchronous return to IDLE, counters cleared, no frame_err, rx_valid ignored. Registers hold their values.
- busy = (state == DATA), registered.
- wr_strobe and frame_err are never high in the same cycle and never last longer than 1 cycle.
- Writes to different addresses never disturb other registers.
- Asynchronous reset mid-frame discards the partial word.

Test Plan:
(Bench parameters: WORDSZ=32, NREGS=4, TIMEOUT_CYC=100.)
1. Reset release, no stimulus -> regs_flat=0, wr_strobe=0, frame_err=0, busy=0.
2. Bytes 0xA2,0xDE,0xAD,0xBE,0xEF -> reg2=0xDEADBEEF, other regs 0; wr_strobe one cycle with wr_addr=2; busy high from after 0xA2 until after 0xEF.
3. Header 0x55, then 0xA7 -> frame_err pulses twice, regs unchanged, busy stays 0.
4. Bytes 0xA1,0x12,0x34, then a 150-cycle gap -> frame_err exactly 100 cycles after 0x34 is accepted, reg1 unchanged. A following frame 0xA1,0x01,0x02,0x03,0x04 gives reg1=0x01020304.
5. With reg2=0xDEADBEEF, send 0xC2 -> reg2=0, wr_strobe with wr_addr=2, no state change.
6. Bytes 0xA3,0x11, then rx_break -> frame_err, reg3 unchanged. Then 0xA3,0x11, with rx_en low for 5 cycles -> no frame_err, busy 0, registers retained.
